// File: rtl/dlx_fetch_stage.sv
// DLX instruction-fetch stage: owns the PC and a single-outstanding-request imem port,
// feeds the IF/ID register and absorbs one response in a skid buffer across decode stalls.
module dlx_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_BLOCKED = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic            skid_valid;
    logic            outstanding;
    logic            squash;

    logic            accept;
    logic            rsp;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_plus4;

    // A response only counts while a request is actually in flight.
    assign accept          = imem_req & imem_gnt;
    assign rsp             = imem_rvalid & outstanding;
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign pc_plus4        = pc + XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            out_pc      <= '0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= '0;
            skid_valid  <= 1'b0;
            outstanding <= 1'b0;
            squash      <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
        end else if (redirect_valid) begin
            // Redirect beats stall: flush IF/ID and the skid, restart at the target.
            pc          <= redirect_target;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            skid_valid  <= 1'b0;
            if (accept) begin
                // Wrong-path request accepted at this very edge: let it drain, drop its data.
                state       <= S_WAIT;
                outstanding <= 1'b1;
                squash      <= 1'b1;
                imem_req    <= 1'b0;
                out_pc      <= imem_addr;
            end else if (outstanding && !imem_rvalid) begin
                state  <= S_WAIT;
                squash <= 1'b1;
            end else begin
                // Nothing in flight (or its data arrives now and is dropped): refetch next cycle.
                state       <= S_REQ;
                outstanding <= 1'b0;
                squash      <= 1'b0;
                imem_req    <= 1'b1;
                imem_addr   <= redirect_target;
            end
        end else begin
            // IF/ID load priority: skid, then live response, then bubble.
            if (!stall) begin
                if (skid_valid) begin
                    if_id_valid <= 1'b1;
                    if_id_instr <= skid_instr;
                    if_id_pc    <= skid_pc;
                    skid_valid  <= 1'b0;
                end else if (rsp && !squash) begin
                    if_id_valid <= 1'b1;
                    if_id_instr <= imem_rdata;
                    if_id_pc    <= out_pc;
                end else begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= NOP_INSTR;
                end
            end

            case (state)
                S_REQ: begin
                    if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end else if (imem_gnt) begin
                        state       <= S_WAIT;
                        imem_req    <= 1'b0;
                        outstanding <= 1'b1;
                        out_pc      <= pc;
                        pc          <= pc_plus4;
                    end
                end
                S_WAIT: begin
                    if (rsp) begin
                        outstanding <= 1'b0;
                        if (!squash && stall) begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= out_pc;
                            skid_valid <= 1'b1;
                            state      <= S_BLOCKED;
                        end else begin
                            squash    <= 1'b0;
                            state     <= S_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end
                    end
                end
                S_BLOCKED: begin
                    if (!stall) begin
                        state     <= S_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlx_fetch_stage.sv
// Directed bench for dlx_fetch_stage with a latency-programmable instruction memory model.
module tb_dlx_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;

    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;

    int compares = 0;
    int errors   = 0;
    int mem_lat  = 1;
    logic stray  = 1'b0;

    logic        m_acc;
    logic [31:0] m_a;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;

    dlx_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc)
    );

    // Wrap-around instance shares all inputs; handshake timing is identical to dut.
    dlx_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut2 (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_valid(valid2), .if_id_instr(instr2), .if_id_pc(pc2)
    );

    always #5 clk = ~clk;

    // Memory: returns 0xA0+addr mem_lat cycles after accept; 'stray' injects an unsolicited beat.
    always @(posedge clk) begin
        m_acc = imem_req & imem_gnt;
        m_a   = imem_addr;
        #1;
        if (rst) begin
            pend        = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (m_acc) begin
                pend  = 1'b1;
                cnt   = mem_lat;
                paddr = m_a;
            end
            if (stray) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end else if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = 32'hA0 + paddr;
                    pend        = 1'b0;
                end
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b1; mem_lat = 1; stray = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b1;
        @(negedge clk); @(negedge clk);
        compares++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        compares++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        compares++; if (addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_addr2: got %h want fffffffc", addr2); end
        compares++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", if_id_valid); end
        compares++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", if_id_instr); end
        compares++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", if_id_pc); end
        rst = 1'b0;
    endtask

    task automatic test_straight;
        do_reset();
        @(negedge clk);
        compares++; if (imem_req !== 1'b1) begin errors++; $display("FAIL st_first_req: got %0b want 1", imem_req); end
        compares++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL st_first_addr: got %h want 00000000", imem_addr); end
        compares++; if (addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL st_wrap_addr0: got %h want fffffffc", addr2); end
        @(negedge clk);
        compares++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_wait_req: got %0b want 0", imem_req); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            compares++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL st_valid%0d: got %0b want 1", k, if_id_valid); end
            compares++; if (if_id_pc !== 32'(4 * k)) begin errors++; $display("FAIL st_pc%0d: got %h want %h", k, if_id_pc, 32'(4 * k)); end
            compares++; if (if_id_instr !== 32'(32'hA0 + 4 * k)) begin errors++; $display("FAIL st_instr%0d: got %h want %h", k, if_id_instr, 32'(32'hA0 + 4 * k)); end
            if (k == 0) begin
                compares++; if (addr2 !== 32'h0) begin errors++; $display("FAIL st_wrap_addr1: got %h want 00000000", addr2); end
                compares++; if (pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL st_wrap_ifpc: got %h want fffffffc", pc2); end
            end
            @(negedge clk);
            compares++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL st_bubble%0d: got %0b want 0", k, if_id_valid); end
        end
    endtask

    task automatic test_gnt_hold;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        @(negedge clk);
        redirect_valid = 1'b0; imem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            compares++; if (imem_req !== 1'b1) begin errors++; $display("FAIL gnt_req%0d: got %0b want 1", i, imem_req); end
            compares++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL gnt_addr%0d: got %h want 00000010", i, imem_addr); end
            if (i < 3) @(negedge clk);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        compares++; if (imem_req !== 1'b0) begin errors++; $display("FAIL gnt_wait_req: got %0b want 0", imem_req); end
        @(negedge clk);
        compares++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL gnt_next_addr: got %h want 00000014", imem_addr); end
        compares++; if (if_id_pc !== 32'h10) begin errors++; $display("FAIL gnt_ifpc: got %h want 00000010", if_id_pc); end
        compares++; if (if_id_instr !== 32'hB0) begin errors++; $display("FAIL gnt_instr: got %h want 000000b0", if_id_instr); end
    endtask

    task automatic test_stall_skid;
        do_reset();
        repeat (5) @(negedge clk);
        compares++; if (if_id_pc !== 32'h4) begin errors++; $display("FAIL sk_pre_pc: got %h want 00000004", if_id_pc); end
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compares++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sk_blk_req: got %0b want 0", imem_req); end
        compares++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL sk_hold_valid: got %0b want 1", if_id_valid); end
        compares++; if (if_id_pc !== 32'h4) begin errors++; $display("FAIL sk_hold_pc: got %h want 00000004", if_id_pc); end
        compares++; if (if_id_instr !== 32'hA4) begin errors++; $display("FAIL sk_hold_instr: got %h want 000000a4", if_id_instr); end
        @(negedge clk);
        compares++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sk_blk_req2: got %0b want 0", imem_req); end
        compares++; if (if_id_pc !== 32'h4) begin errors++; $display("FAIL sk_hold_pc2: got %h want 00000004", if_id_pc); end
        stall = 1'b0;
        @(negedge clk);
        compares++; if (if_id_pc !== 32'h8) begin errors++; $display("FAIL sk_out_pc: got %h want 00000008", if_id_pc); end
        compares++; if (if_id_instr !== 32'hA8) begin errors++; $display("FAIL sk_out_instr: got %h want 000000a8", if_id_instr); end
        compares++; if (imem_req !== 1'b1) begin errors++; $display("FAIL sk_rereq: got %0b want 1", imem_req); end
        compares++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL sk_rereq_addr: got %h want 0000000c", imem_addr); end
        @(negedge clk);
        @(negedge clk);
        compares++; if (if_id_pc !== 32'hC) begin errors++; $display("FAIL sk_next_pc: got %h want 0000000c", if_id_pc); end
    endtask

    task automatic test_redirect_squash;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h20; mem_lat = 3;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        compares++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rs_flush_valid: got %0b want 0", if_id_valid); end
        compares++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rs_wait_req: got %0b want 0", imem_req); end
        @(negedge clk);
        @(negedge clk);
        mem_lat = 1;
        compares++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rs_req: got %0b want 1", imem_req); end
        compares++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rs_addr: got %h want 00000100", imem_addr); end
        compares++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rs_dropped: got %0b want 0", if_id_valid); end
        @(negedge clk);
        @(negedge clk);
        compares++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL rs_new_valid: got %0b want 1", if_id_valid); end
        compares++; if (if_id_pc !== 32'h100) begin errors++; $display("FAIL rs_new_pc: got %h want 00000100", if_id_pc); end
        compares++; if (if_id_instr !== 32'h1A0) begin errors++; $display("FAIL rs_new_instr: got %h want 000001a0", if_id_instr); end
    endtask

    task automatic test_redirect_skid;
        do_reset();
        repeat (5) @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        compares++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rk_flush_valid: got %0b want 0", if_id_valid); end
        compares++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rk_req: got %0b want 1", imem_req); end
        compares++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rk_addr: got %h want 00000200", imem_addr); end
        @(negedge clk);
        stall = 1'b0;
        compares++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rk_hold_bubble: got %0b want 0", if_id_valid); end
        @(negedge clk);
        compares++; if (if_id_pc !== 32'h200) begin errors++; $display("FAIL rk_pc: got %h want 00000200", if_id_pc); end
        compares++; if (if_id_instr !== 32'h2A0) begin errors++; $display("FAIL rk_instr: got %h want 000002a0", if_id_instr); end
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        repeat (3) @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        compares++; if (if_id_instr !== 32'hA0) begin errors++; $display("FAIL rw_pre_instr: got %h want 000000a0", if_id_instr); end
        compares++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rw_pre_addr: got %h want 00000004", imem_addr); end
        rst = 1'b1;
        #1;
        compares++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_req: got %0b want 0", imem_req); end
        compares++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rw_addr: got %h want 00000000", imem_addr); end
        compares++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rw_valid: got %0b want 0", if_id_valid); end
        compares++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL rw_instr: got %h want 00000000", if_id_instr); end
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; imem_gnt = 1'b0; stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        compares++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rw_first_req: got %0b want 1", imem_req); end
        @(negedge clk);
        compares++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rw_stray_ignored: got %0b want 0", if_id_valid); end
        imem_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compares++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL rw_resume_valid: got %0b want 1", if_id_valid); end
        compares++; if (if_id_instr !== 32'hA0) begin errors++; $display("FAIL rw_resume_instr: got %h want 000000a0", if_id_instr); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_gnt_hold();
        test_stall_skid();
        test_redirect_squash();
        test_redirect_skid();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
